// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor, one BLK-bit block per stage; latency WIDTH/BLK cycles.
// Backpressure: out_valid && !out_ready freezes every stage, and in_ready is that advance enable.
module csel_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLK;

    // Ripple block add; returns {carry out, carry into block MSB, sum}.
    function automatic logic [BLK+1:0] blk_add(input logic [BLK-1:0] x, input logic [BLK-1:0] y,
                                               input logic ci);
        logic [BLK-1:0] s;
        logic           c;
        logic           cm;
        c  = ci;
        cm = ci;
        s  = '0;
        for (int i = 0; i < BLK; i++) begin
            if (i == BLK - 1) cm = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, cm, s};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             vld_q [NBLK];
    logic             c_q   [NBLK];
    logic [WIDTH-1:0] sum_q [NBLK];
    logic [WIDTH-1:0] a_q   [NBLK];
    logic [WIDTH-1:0] b_q   [NBLK];
    logic [BLK+1:0]   res   [NBLK];
    logic             ovf_q;

    assign adv      = !vld_q[NBLK-1] || out_ready;
    assign in_ready = adv;
    assign bx       = sub ? ~b : b;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] nxt;
        logic             vin;

        if (k == 0) begin : g_first
            assign opa    = a;
            assign opb    = bx;
            assign prev   = '0;
            assign vin    = in_valid;
            assign res[0] = blk_add(a[BLK-1:0], bx[BLK-1:0], sub);
        end else begin : g_rest
            logic [BLK+1:0] r0;
            logic [BLK+1:0] r1;
            assign opa    = a_q[k-1];
            assign opb    = b_q[k-1];
            assign prev   = sum_q[k-1];
            assign vin    = vld_q[k-1];
            assign r0     = blk_add(opa[k*BLK +: BLK], opb[k*BLK +: BLK], 1'b0);
            assign r1     = blk_add(opa[k*BLK +: BLK], opb[k*BLK +: BLK], 1'b1);
            // Registered carry of the previous block picks the precomputed result.
            assign res[k] = c_q[k-1] ? r1 : r0;
        end

        always_comb begin
            nxt                = prev;
            nxt[k*BLK +: BLK]  = res[k][BLK-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q[k] <= 1'b0;
                c_q[k]   <= 1'b0;
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end else if (adv) begin
                vld_q[k] <= vin;
                c_q[k]   <= res[k][BLK+1];
                sum_q[k] <= nxt;
                a_q[k]   <= opa;
                b_q[k]   <= opb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= res[NBLK-1][BLK] ^ res[NBLK-1][BLK+1];
        end
    end

    assign out_valid = vld_q[NBLK-1];
    assign sum       = sum_q[NBLK-1];
    assign cout      = c_q[NBLK-1];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed and short random-stream checks of csel_adder_pipe at WIDTH=16, BLK=4.
module tb_csel_adder_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    csel_adder_pipe #(.WIDTH(16), .BLK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] es;
        logic        ec;
        logic        eo;
        string       nm;
    } vec_t;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
    } op_t;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] yb;
        logic [16:0] f;
        res_t        r;
        yb  = s ? ~y : y;
        f   = {1'b0, x} + {1'b0, yb} + {16'b0, s};
        r.s = f[15:0];
        r.c = f[16];
        r.o = (x[15] == yb[15]) && (r.s[15] != x[15]);
        return r;
    endfunction

    // Pipeline must be empty on entry; checks latency, single output beat and result.
    task automatic run_single(input vec_t v);
        int first;
        int nv;
        first     = -1;
        nv        = 0;
        a         = v.a;
        b         = v.b;
        sub       = v.s;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        chk({v.nm, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (out_valid) begin
                nv++;
                if (first < 0) begin
                    first = c;
                    chk({v.nm, " sum"},  32'(sum),  32'(v.es));
                    chk({v.nm, " cout"}, 32'(cout), 32'(v.ec));
                    chk({v.nm, " ovf"},  32'(ovf),  32'(v.eo));
                end
            end
        end
        chk({v.nm, " latency"}, 32'(first), 32'd3);
        chk({v.nm, " beats"},   32'(nv),    32'd1);
    endtask

    vec_t vt[8];
    op_t  ops[8];
    res_t expq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nv;
        int   sent;
        int   recv;
        int   stall;
        logic acc;
        res_t r;

        vt[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "add_00ff_1"};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff_1"};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_7fff_1"};
        vt[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_5_7"};
        vt[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000_1"};
        vt[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add_1234_4321"};
        vt[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_0_0"};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "add_8000_8000"};

        // Reset with an op presented; it must not be accepted.
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1111;
        b         = 16'h2222;
        sub       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum",       32'(sum),       32'd0);
        chk("reset cout",      32'(cout),      32'd0);
        chk("reset ovf",       32'(ovf),       32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) nv++;
        end
        chk("idle no output", 32'(nv), 32'd0);

        for (int i = 0; i < 8; i++) run_single(vt[i]);

        // Back-to-back stream with a 3-cycle stall after the 2nd result.
        for (int i = 0; i < 8; i++) begin
            ops[i].a = 16'($urandom);
            ops[i].b = 16'($urandom);
            ops[i].s = 1'($urandom_range(0, 1));
        end
        sent  = 0;
        recv  = 0;
        stall = 0;
        for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
            out_ready = (stall == 0);
            #1;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("stream extra output", 32'(out_valid), 32'd0);
                end else if (out_ready) begin
                    chk("stream sum",  32'(sum),  32'(expq[0].s));
                    chk("stream cout", 32'(cout), 32'(expq[0].c));
                    chk("stream ovf",  32'(ovf),  32'(expq[0].o));
                    void'(expq.pop_front());
                    recv++;
                    if (recv == 2) stall = 3;
                end else begin
                    chk("stall in_ready", 32'(in_ready), 32'd0);
                    chk("stall sum",      32'(sum),      32'(expq[0].s));
                    chk("stall cout",     32'(cout),     32'(expq[0].c));
                    chk("stall ovf",      32'(ovf),      32'(expq[0].o));
                    stall--;
                end
            end
            if (sent < 8) begin
                in_valid = 1'b1;
                a        = ops[sent].a;
                b        = ops[sent].b;
                sub      = ops[sent].s;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                r = model(ops[sent].a, ops[sent].b, ops[sent].s);
                expq.push_back(r);
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream results", 32'(recv), 32'd8);
        chk("stream stall seen", 32'(stall), 32'd0);

        // Drain, then reset with three ops in flight.
        repeat (6) tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'h0100 * 16'(i + 1);
            b        = 16'h0003;
            sub      = 1'b0;
            tick();
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h1111;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("flush out_valid", 32'(out_valid), 32'd0);
        run_single('{16'h4000, 16'h0FFF, 1'b1, 16'h3001, 1'b1, 1'b0, "post_reset_sub"});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/csel_adder_pipe.md
# csel_adder_pipe

Parametrised, pipelined carry-select adder/subtractor, successor to the fixed 8-bit combinational carry-select adder. Operands are split into `WIDTH/BLK` blocks. Each block is computed for carry-in 0 and 1, and the select carry from the previous block is registered between blocks. The result is one add/sub per clock at `WIDTH/BLK` cycles latency, with a valid/ready handshake on both sides. It sits in the datapath wherever a wide adder must close timing at high clock rate.

## Interface
Parameters:
- `WIDTH`, 16: operand and sum width in bits. Must be a multiple of `BLK` and ≥ `BLK`.
- `BLK`, 4: block width; one pipeline stage per block. `NBLK = WIDTH/BLK`.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: operands and mode present.
- `in_ready` output 1: block can accept this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `sub` input 1: 0 → A+B; 1 → A−B, computed as A + ~B + 1.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: result, modulo 2^WIDTH.
- `cout` output 1: carry out of the MSB. For subtraction, 1 = no borrow (A ≥ B unsigned).
- `ovf` output 1: signed overflow, equal to carry-into-MSB XOR `cout`.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Global advance enable `adv = !out_valid || out_ready`, and `in_ready = adv`.
  - When `adv` = 0, every pipeline register holds.
  - When `adv` = 1, every stage shifts one position and stage 0 loads the new operands, or a bubble with valid = 0 if `in_valid` = 0.
- Stage 0 (input capture):
  - Form `b' = sub ? ~b : b` and `c0 = sub`.
  - Block 0 is computed directly with carry-in `c0`. Register its sum bits, its carry out, and the untouched upper operand bits of `a` and `b'`.
- Stage k (1 ≤ k < NBLK):
  - Block k computes two `BLK`-bit ripple sums, `s0` with carry-in 0 and `s1` with carry-in 1, each with its own carry out.
  - The registered carry from stage k−1 selects `sum_k` and `carry_k`.
  - Lower sum bits already resolved are passed forward unchanged. Remaining upper operand bits are passed forward.
- Last stage: its register holds the full `sum`, `cout` and `ovf`. These are the output registers; outputs come straight from flops.
- `ovf` is computed in the block that contains the MSB, from the carry into the MSB bit and that block's selected carry out.
- Each stage carries its own valid bit. `out_valid` is the valid bit of the last stage.
- `sub` does not need to survive past stage 0, because it is folded into `b'` and `c0`.
- `NBLK` = 1 degenerates to a single registered adder with latency 1.

## Timing
- Reset (`rst` = 1 at a clock edge):
  - All stage valid bits clear, so `out_valid` = 0.
  - `sum` = 0, `cout` = 0, `ovf` = 0.
  - `in_ready` reads 1 in the cycle after reset, because `out_valid` = 0.
  - Any operations in flight are discarded with no partial output.
  - Inputs presented during the `rst` cycle are not accepted.
- Latency: an operand accepted at edge n produces `out_valid` = 1 with its result after edge n+NBLK-1, i.e. visible for NBLK cycles counting the accept cycle. That is 4 cycles for the defaults.
- Throughput: one accept per cycle while `out_ready` = 1. No bubbles are inserted.
- Backpressure:
  - `out_valid` = 1 with `out_ready` = 0 freezes the entire pipeline, including bubbles.
  - `in_ready` is combinationally low in that cycle.
  - Results are never dropped, duplicated or reordered.
- Simultaneous output transfer and input accept in the same cycle is allowed. Both happen.
- Outputs `sum`, `cout` and `ovf` hold stable while `out_valid` = 1 and `out_ready` = 0.
- Their values are don't-care while `out_valid` = 0, except at reset, where they are 0.

## Test plan
All cases use WIDTH=16, BLK=4, `out_ready`=1 unless stated.
- Reset, then idle → `out_valid`=0, `sum`=0x0000, `cout`=0, `ovf`=0, `in_ready`=1.
- Add 0x00FF + 0x0001, single beat → `sum`=0x0100, `cout`=0, `ovf`=0. `out_valid` is high exactly one cycle, 3 edges after the accept edge. This checks carry crossing a block boundary.
- Add 0xFFFF + 0x0001 → `sum`=0x0000, `cout`=1, `ovf`=0. Add 0x7FFF + 0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1.
- Subtract 0x0005 − 0x0007 → `sum`=0xFFFE, `cout`=0, `ovf`=0. Subtract 0x8000 − 0x0001 → `sum`=0x7FFF, `cout`=1, `ovf`=1.
- Stream 8 back-to-back random add/sub ops, with `out_ready` low for 3 cycles after the 2nd result. Check:
  - `in_ready` is low during the stall.
  - Outputs are stable during the stall.
  - All 8 results match the golden model, in order, with no loss or duplication.
- Assert `rst` for one cycle while 3 ops are in flight → no output from those ops. A new op accepted right after reset returns correctly after 4 cycles.
